// File: rtl/ddr2_cmd_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_cmd_monitor_pkg
// Brief    : Shared widths, pin/command encodings, error indices and init FSM
//            state encodings for the DDR2 command-bus monitor.
// Revision : 1.0 - initial release
// ============================================================================
package ddr2_cmd_monitor_pkg;

    localparam int c_ba_bits   = 3;
    localparam int c_addr_bits = 13;

    // Pin command encodings, {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_pin_nop  = 4'b0111;
    localparam logic [3:0] c_pin_pre  = 4'b0010;
    localparam logic [3:0] c_pin_aref = 4'b0001;
    localparam logic [3:0] c_pin_lmr  = 4'b0000;
    localparam logic [3:0] c_pin_act  = 4'b0011;
    localparam logic [3:0] c_pin_rd   = 4'b0101;
    localparam logic [3:0] c_pin_wr   = 4'b0100;
    localparam logic [3:0] c_pin_ill  = 4'b0110;

    localparam logic [2:0] c_cmd_nop  = 3'd0;
    localparam logic [2:0] c_cmd_pre  = 3'd1;
    localparam logic [2:0] c_cmd_prea = 3'd2;
    localparam logic [2:0] c_cmd_aref = 3'd3;
    localparam logic [2:0] c_cmd_lmr  = 3'd4;
    localparam logic [2:0] c_cmd_act  = 3'd5;
    localparam logic [2:0] c_cmd_rd   = 3'd6;
    localparam logic [2:0] c_cmd_wr   = 3'd7;

    localparam logic [1:0] c_err_trp  = 2'd0;
    localparam logic [1:0] c_err_trfc = 2'd1;
    localparam logic [1:0] c_err_tmrd = 2'd2;
    localparam int         c_err_seq  = 3;
    localparam int         c_err_bank = 4;
    localparam int         c_err_refi = 5;

    // Sequential encoding: each init step advances to the next code
    localparam logic [3:0] c_st_wait_cke  = 4'd0;
    localparam logic [3:0] c_st_prea1     = 4'd1;
    localparam logic [3:0] c_st_emr2      = 4'd2;
    localparam logic [3:0] c_st_emr3      = 4'd3;
    localparam logic [3:0] c_st_emr1      = 4'd4;
    localparam logic [3:0] c_st_mr_dllrst = 4'd5;
    localparam logic [3:0] c_st_prea2     = 4'd6;
    localparam logic [3:0] c_st_aref1     = 4'd7;
    localparam logic [3:0] c_st_aref2     = 4'd8;
    localparam logic [3:0] c_st_mr_final  = 4'd9;
    localparam logic [3:0] c_st_ready     = 4'd10;

    typedef enum logic [1:0] {
        MR_SEL_MR   = 2'd0,
        MR_SEL_EMR1 = 2'd1,
        MR_SEL_EMR2 = 2'd2,
        MR_SEL_EMR3 = 2'd3
    } mr_sel_e;

endpackage : ddr2_cmd_monitor_pkg
`default_nettype wire

// File: rtl/ddr2_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_cmd_decode
// Brief    : Combinational DDR2 pin-to-command decode with mode-register select.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_cmd_decode
    import ddr2_cmd_monitor_pkg::*;
(
    input  logic       i_cke,
    input  logic       i_cs_n,
    input  logic       i_ras_n,
    input  logic       i_cas_n,
    input  logic       i_we_n,
    input  logic       i_a10,
    input  logic [1:0] i_ba,
    output logic       o_vld,
    output logic [2:0] o_code,
    output logic       o_illegal,
    output logic [1:0] o_mr_sel
);

    always_comb begin
        o_code    = c_cmd_nop;
        o_illegal = 1'b0;
        if (i_cke) begin
            case ({i_cs_n, i_ras_n, i_cas_n, i_we_n})
                c_pin_pre:  o_code = i_a10 ? c_cmd_prea : c_cmd_pre;
                c_pin_aref: o_code = c_cmd_aref;
                c_pin_lmr:  o_code = c_cmd_lmr;
                c_pin_act:  o_code = c_cmd_act;
                c_pin_rd:   o_code = c_cmd_rd;
                c_pin_wr:   o_code = c_cmd_wr;
                c_pin_ill:  o_illegal = 1'b1;
                default:    o_code = c_cmd_nop;
            endcase
        end
    end

    assign o_vld    = (o_code != c_cmd_nop);
    assign o_mr_sel = i_ba;

endmodule : ddr2_cmd_decode
`default_nettype wire

// File: rtl/ddr2_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_cmd_monitor
// Brief    : Passive DDR2 command-bus monitor: decodes commands, tracks the
//            power-up init sequence, bank state and tRP/tRFC/tMRD spacing.
// Options  : DDR2_MON_REFI_CHECK_EN enables the refresh-interval overrun check.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_cmd_monitor
    import ddr2_cmd_monitor_pkg::*;
#(
    parameter int BA_BITS    = c_ba_bits,
    parameter int ADDR_BITS  = c_addr_bits,
    parameter int T_RP       = 4,
    parameter int T_RFC      = 26,
    parameter int T_MRD      = 2,
    parameter int T_REFI_MAX = 1560
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    ddr2_cke,
    input  logic                    ddr2_cs_n,
    input  logic                    ddr2_ras_n,
    input  logic                    ddr2_cas_n,
    input  logic                    ddr2_we_n,
    input  logic [BA_BITS-1:0]      ddr2_ba,
    input  logic [ADDR_BITS-1:0]    ddr2_addr,
    output logic                    cmd_vld,
    output logic [2:0]              cmd_code,
    output logic                    init_done,
    output logic [(2**BA_BITS)-1:0] bank_open,
    output logic [15:0]             aref_cnt,
    output logic [5:0]              err,
    output logic                    err_pulse
);

    localparam int NBANKS = 2**BA_BITS;

    logic              w_vld;
    logic [2:0]        w_code;
    logic              w_illegal;
    logic [1:0]        w_mr_sel;
    logic              w_addr_unused;

    logic [3:0]        r_state;
    logic [15:0]       r_timer;
    logic [1:0]        r_tag;
    logic [NBANKS-1:0] r_bank;
    logic [15:0]       r_aref_cnt;
    logic [5:0]        r_err;
    logic              r_err_pulse;
    logic              r_cmd_vld;
    logic [2:0]        r_cmd_code;

    logic              w_expect;
    logic              w_is_lmr;
    logic [3:0]        w_state_nxt;
    logic [15:0]       w_timer_nxt;
    logic [1:0]        w_tag_nxt;
    logic [NBANKS-1:0] w_bank_nxt;
    logic [NBANKS-1:0] w_ba_oh;
    logic [4:0]        w_err_base;
    logic              w_err_refi;
    logic [5:0]        w_err_new;

    ddr2_cmd_decode u_decode (
        .i_cke     (ddr2_cke),
        .i_cs_n    (ddr2_cs_n),
        .i_ras_n   (ddr2_ras_n),
        .i_cas_n   (ddr2_cas_n),
        .i_we_n    (ddr2_we_n),
        .i_a10     (ddr2_addr[10]),
        .i_ba      (ddr2_ba[1:0]),
        .o_vld     (w_vld),
        .o_code    (w_code),
        .o_illegal (w_illegal),
        .o_mr_sel  (w_mr_sel)
    );

    // Only A8 and A10 carry meaning for this monitor
    assign w_addr_unused = ^ddr2_addr;

    assign w_ba_oh  = {{(NBANKS-1){1'b0}}, 1'b1} << ddr2_ba;
    assign w_is_lmr = (w_code == c_cmd_lmr);

    always_comb begin
        w_expect    = 1'b0;
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_tag_nxt   = r_tag;
        w_bank_nxt  = r_bank;
        w_err_base  = '0;

        case (r_state)
            c_st_prea1,
            c_st_prea2:     w_expect = (w_code == c_cmd_prea);
            c_st_emr2:      w_expect = w_is_lmr && (w_mr_sel == MR_SEL_EMR2);
            c_st_emr3:      w_expect = w_is_lmr && (w_mr_sel == MR_SEL_EMR3);
            c_st_emr1:      w_expect = w_is_lmr && (w_mr_sel == MR_SEL_EMR1);
            c_st_mr_dllrst: w_expect = w_is_lmr && (w_mr_sel == MR_SEL_MR) && ddr2_addr[8];
            c_st_aref1,
            c_st_aref2:     w_expect = (w_code == c_cmd_aref);
            c_st_mr_final:  w_expect = w_is_lmr && (w_mr_sel == MR_SEL_MR) && !ddr2_addr[8];
            default:        w_expect = 1'b0;
        endcase

        if (r_state == c_st_wait_cke) begin
            if (ddr2_cke)
                w_state_nxt = c_st_prea1;
            if (w_vld)
                w_err_base[c_err_seq] = 1'b1;
        end else if ((r_state != c_st_ready) && w_vld) begin
            if (w_expect)
                w_state_nxt = r_state + 4'd1;
            else
                w_err_base[c_err_seq] = 1'b1;
        end

        if (w_illegal)
            w_err_base[c_err_seq] = 1'b1;
        if ((r_state != c_st_ready) &&
            ((w_code == c_cmd_act) || (w_code == c_cmd_rd) || (w_code == c_cmd_wr)))
            w_err_base[c_err_seq] = 1'b1;

        // The tag remembers which spacing rule the running count belongs to
        if (w_vld && (r_timer != '0))
            w_err_base[r_tag] = 1'b1;
        if (r_timer != '0)
            w_timer_nxt = r_timer - 16'd1;

        case (w_code)
            c_cmd_pre, c_cmd_prea: begin
                w_timer_nxt = 16'(T_RP - 1);
                w_tag_nxt   = c_err_trp;
            end
            c_cmd_aref: begin
                w_timer_nxt = 16'(T_RFC - 1);
                w_tag_nxt   = c_err_trfc;
            end
            c_cmd_lmr: begin
                w_timer_nxt = 16'(T_MRD - 1);
                w_tag_nxt   = c_err_tmrd;
            end
            default: ;
        endcase

        case (w_code)
            c_cmd_act: begin
                if ((r_bank & w_ba_oh) != '0)
                    w_err_base[c_err_bank] = 1'b1;
                w_bank_nxt = r_bank | w_ba_oh;
            end
            c_cmd_rd, c_cmd_wr: begin
                if ((r_bank & w_ba_oh) == '0)
                    w_err_base[c_err_bank] = 1'b1;
            end
            c_cmd_pre:  w_bank_nxt = r_bank & ~w_ba_oh;
            c_cmd_prea: w_bank_nxt = '0;
            c_cmd_aref: begin
                if (r_bank != '0)
                    w_err_base[c_err_bank] = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DDR2_MON_REFI_CHECK_EN
    logic [15:0] r_refi_cnt;
    logic [15:0] w_refi_nxt;
    logic        w_refi_hit;

    // Counter saturates at the limit so each overrun flags exactly once
    always_comb begin
        w_refi_nxt = r_refi_cnt + 16'd1;
        w_refi_hit = 1'b0;
        if ((r_state != c_st_ready) || (w_code == c_cmd_aref))
            w_refi_nxt = '0;
        else if (r_refi_cnt == 16'(T_REFI_MAX))
            w_refi_nxt = r_refi_cnt;
        else
            w_refi_hit = (w_refi_nxt == 16'(T_REFI_MAX));
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            r_refi_cnt <= '0;
        else
            r_refi_cnt <= w_refi_nxt;
    end

    assign w_err_refi = w_refi_hit;
`else
    assign w_err_refi = 1'b0;
`endif

    assign w_err_new = {w_err_refi, w_err_base};

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_wait_cke;
            r_timer     <= '0;
            r_tag       <= c_err_trp;
            r_bank      <= '0;
            r_aref_cnt  <= '0;
            r_err       <= '0;
            r_err_pulse <= 1'b0;
            r_cmd_vld   <= 1'b0;
            r_cmd_code  <= c_cmd_nop;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_tag       <= w_tag_nxt;
            r_bank      <= w_bank_nxt;
            if ((w_code == c_cmd_aref) && (r_aref_cnt != 16'hFFFF))
                r_aref_cnt <= r_aref_cnt + 16'd1;
            r_err       <= r_err | w_err_new;
            r_err_pulse <= |(w_err_new & ~r_err);
            r_cmd_vld   <= w_vld;
            r_cmd_code  <= w_code;
        end
    end

    assign cmd_vld   = r_cmd_vld;
    assign cmd_code  = r_cmd_code;
    assign init_done = (r_state == c_st_ready);
    assign bank_open = r_bank;
    assign aref_cnt  = r_aref_cnt;
    assign err       = r_err;
    assign err_pulse = r_err_pulse;

endmodule : ddr2_cmd_monitor
`default_nettype wire

// File: tb/tb_ddr2_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_cmd_monitor
// Brief    : Directed + randomized bench for ddr2_cmd_monitor with a
//            cycle-stamp reference model of the command-bus rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_cmd_monitor;

    localparam int BA_BITS    = 3;
    localparam int ADDR_BITS  = 13;
    localparam int T_RP       = 4;
    localparam int T_RFC      = 26;
    localparam int T_MRD      = 2;
    localparam int T_REFI_MAX = 1560;
`ifdef DDR2_MON_REFI_CHECK_EN
    localparam bit REFI_EN = 1'b1;
`else
    localparam bit REFI_EN = 1'b0;
`endif

    localparam int K_NOP = 0, K_PRE = 1, K_PREA = 2, K_AREF = 3, K_LMR = 4;
    localparam int K_ACT = 5, K_RD = 6, K_WR = 7, K_ILL = 8;

    logic        ck = 1'b0;
    logic        rst_n = 1'b1;
    logic        ddr2_cke = 1'b0;
    logic        ddr2_cs_n = 1'b1, ddr2_ras_n = 1'b1, ddr2_cas_n = 1'b1, ddr2_we_n = 1'b1;
    logic [2:0]  ddr2_ba = '0;
    logic [12:0] ddr2_addr = '0;
    logic        cmd_vld, init_done, err_pulse;
    logic [2:0]  cmd_code;
    logic [7:0]  bank_open;
    logic [15:0] aref_cnt;
    logic [5:0]  err;

    always #5 ck = ~ck;

    ddr2_cmd_monitor #(
        .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .T_RP(T_RP), .T_RFC(T_RFC),
        .T_MRD(T_MRD), .T_REFI_MAX(T_REFI_MAX)
    ) dut (
        .ck(ck), .rst_n(rst_n), .ddr2_cke(ddr2_cke), .ddr2_cs_n(ddr2_cs_n),
        .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n), .ddr2_we_n(ddr2_we_n),
        .ddr2_ba(ddr2_ba), .ddr2_addr(ddr2_addr), .cmd_vld(cmd_vld), .cmd_code(cmd_code),
        .init_done(init_done), .bank_open(bank_open), .aref_cnt(aref_cnt),
        .err(err), .err_pulse(err_pulse)
    );

    int checks = 0;
    int failures = 0;

    // Model: absolute cycle stamps instead of a down-counter
    int         cyc = 0;
    int         busy_until = 0;
    int         busy_tag = 0;
    int         m_step = 0;          // 0 = waiting for CKE, 10 = ready
    int         refi_anchor = 0;
    int         m_aref = 0;
    logic [7:0] m_bank = '0;
    logic [5:0] m_err = '0;
    logic       m_pulse = 1'b0;
    logic       m_vld = 1'b0;
    logic [2:0] m_code = '0;
    int         seq_code[10];
    int         seq_ba[10];
    int         seq_a8[10];          // 2 = A8 don't care

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        busy_until = 0; busy_tag = 0; m_step = 0; refi_anchor = 0; m_aref = 0;
        m_bank = '0; m_err = '0; m_pulse = 1'b0; m_vld = 1'b0; m_code = '0;
    endtask

    function automatic bit seq_match(input int st, input int code, input int b, input logic [12:0] a);
        if (code != seq_code[st]) return 1'b0;
        if (code != K_LMR) return 1'b1;
        if ((b & 3) != seq_ba[st]) return 1'b0;
        return (seq_a8[st] == 2) || (int'(a[8]) == seq_a8[st]);
    endfunction

    task automatic model(input logic cke, input int code, input int b, input logic [12:0] a);
        logic [5:0] ne;
        bit         valid, was_ready;
        int         bi;
        ne = '0;
        valid = cke && (code != K_NOP) && (code != K_ILL);
        was_ready = (m_step == 10);
        bi = b & 7;
        if (valid && (cyc < busy_until)) ne[busy_tag] = 1'b1;
        if (valid && (code == K_PRE || code == K_PREA)) begin busy_until = cyc + T_RP;  busy_tag = 0; end
        if (valid && code == K_AREF)                    begin busy_until = cyc + T_RFC; busy_tag = 1; end
        if (valid && code == K_LMR)                     begin busy_until = cyc + T_MRD; busy_tag = 2; end
        if (cke && code == K_ILL) ne[3] = 1'b1;
        if (valid && !was_ready && code >= K_ACT) ne[3] = 1'b1;
        if (m_step == 0) begin
            if (valid) ne[3] = 1'b1;
            if (cke) m_step = 1;
        end else if (!was_ready && valid) begin
            if (seq_match(m_step, code, b, a)) m_step++;
            else ne[3] = 1'b1;
        end
        if (valid) begin
            case (code)
                K_ACT:      begin if (m_bank[bi]) ne[4] = 1'b1; m_bank[bi] = 1'b1; end
                K_RD, K_WR: if (!m_bank[bi]) ne[4] = 1'b1;
                K_PRE:      m_bank[bi] = 1'b0;
                K_PREA:     m_bank = '0;
                K_AREF:     begin if (m_bank != 0) ne[4] = 1'b1; if (m_aref < 65535) m_aref++; end
                default: ;
            endcase
        end
        if (REFI_EN) begin
            if (was_ready) begin
                if (valid && code == K_AREF) refi_anchor = cyc;
                else if (cyc - refi_anchor == T_REFI_MAX) ne[5] = 1'b1;
            end else if (m_step == 10) begin
                refi_anchor = cyc;
            end
        end
        m_pulse = |(ne & ~m_err);
        m_err   = m_err | ne;
        m_vld   = valid;
        m_code  = valid ? 3'(code) : 3'd0;
        cyc++;
    endtask

    task automatic check_all();
        chk("cmd_vld",   32'(cmd_vld),   32'(m_vld));
        chk("cmd_code",  32'(cmd_code),  32'(m_code));
        chk("init_done", 32'(init_done), 32'(m_step == 10));
        chk("bank_open", 32'(bank_open), 32'(m_bank));
        chk("aref_cnt",  32'(aref_cnt),  32'(m_aref));
        chk("err",       32'(err),       32'(m_err));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    endtask

    task automatic step(input logic cke, input int code, input int b, input logic [12:0] a_in);
        logic [3:0]  pins;
        logic [12:0] a;
        a = a_in;
        case (code)
            K_PRE:   begin pins = 4'b0010; a[10] = 1'b0; end
            K_PREA:  begin pins = 4'b0010; a[10] = 1'b1; end
            K_AREF:  pins = 4'b0001;
            K_LMR:   pins = 4'b0000;
            K_ACT:   pins = 4'b0011;
            K_RD:    pins = 4'b0101;
            K_WR:    pins = 4'b0100;
            K_ILL:   pins = 4'b0110;
            default: pins = ($urandom_range(0, 1) == 1) ? {1'b1, 3'($urandom_range(0, 7))} : 4'b0111;
        endcase
        ddr2_cke = cke;
        {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} = pins;
        ddr2_ba = 3'(b);
        ddr2_addr = a;
        @(posedge ck);
        #1;
        model(cke, code, b, a);
        check_all();
    endtask

    task automatic nop();
        step(1'b1, K_NOP, 0, 13'($urandom));
    endtask

    task automatic issue_legal(input int code, input int b, input int a8);
        logic [12:0] a;
        a = 13'($urandom);
        if (a8 != 2) a[8] = a8[0];
        while (cyc < busy_until) nop();
        repeat ($urandom_range(0, 2)) nop();
        step(1'b1, code, b, a);
    endtask

    task automatic power_up();
        repeat ($urandom_range(1, 3)) step(1'b0, K_ACT, 0, 13'($urandom));
        nop();
    endtask

    task automatic init_from(input int first, input int last);
        for (int k = first; k <= last; k++) issue_legal(seq_code[k], seq_ba[k], seq_a8[k]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_cmd_vld",   32'(cmd_vld),   0);
        chk("rst_cmd_code",  32'(cmd_code),  0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_bank_open", 32'(bank_open), 0);
        chk("rst_aref_cnt",  32'(aref_cnt),  0);
        chk("rst_err",       32'(err),       0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        model_reset();
        @(negedge ck);
        rst_n = 1'b1;
    endtask

    initial begin
        seq_code[0] = K_NOP;  seq_ba[0] = 0; seq_a8[0] = 2;
        seq_code[1] = K_PREA; seq_ba[1] = 0; seq_a8[1] = 2;
        seq_code[2] = K_LMR;  seq_ba[2] = 2; seq_a8[2] = 2;
        seq_code[3] = K_LMR;  seq_ba[3] = 3; seq_a8[3] = 2;
        seq_code[4] = K_LMR;  seq_ba[4] = 1; seq_a8[4] = 2;
        seq_code[5] = K_LMR;  seq_ba[5] = 0; seq_a8[5] = 1;
        seq_code[6] = K_PREA; seq_ba[6] = 0; seq_a8[6] = 2;
        seq_code[7] = K_AREF; seq_ba[7] = 0; seq_a8[7] = 2;
        seq_code[8] = K_AREF; seq_ba[8] = 0; seq_a8[8] = 2;
        seq_code[9] = K_LMR;  seq_ba[9] = 0; seq_a8[9] = 0;

        #1;
        do_reset();

        // Legal power-up sequence
        power_up();
        init_from(1, 9);
        chk("init_done_legal", 32'(init_done), 1);
        chk("err_legal",       32'(err),       0);
        chk("aref_cnt_legal",  32'(aref_cnt),  2);

        // PREA then AREF three cycles later violates tRP
        issue_legal(K_PREA, 0, 2);
        nop();
        nop();
        step(1'b1, K_AREF, 0, 13'($urandom));
        chk("trp_err0",   32'(err[0]),    1);
        chk("trp_pulse",  32'(err_pulse), 1);
        chk("trp_aref",   32'(aref_cnt),  3);
        nop();
        chk("trp_pulse_drop", 32'(err_pulse), 0);

        // Bank tracking
        issue_legal(K_ACT, 2, 2);
        step(1'b1, K_ACT, 2, 13'($urandom));
        chk("act_twice_err4", 32'(err[4]), 1);
        chk("act_bank2_open", 32'(bank_open[2]), 1);
        step(1'b1, K_RD, 5, 13'($urandom));
        chk("rd_closed_err4", 32'(err[4]), 1);
        issue_legal(K_PREA, 0, 2);
        chk("prea_closes_all", 32'(bank_open), 0);

        // Spacing boundaries: exactly T_RP is legal, T_MRD-1 and T_RFC-1 are not
        repeat (T_RP - 1) nop();
        step(1'b1, K_LMR, 0, 13'($urandom));
        chk("trp_exact_no_pulse", 32'(err_pulse), 0);
        step(1'b1, K_LMR, 0, 13'($urandom));
        chk("tmrd_early_err2", 32'(err[2]), 1);
        issue_legal(K_AREF, 0, 2);
        repeat (T_RFC - 2) nop();
        step(1'b1, K_AREF, 0, 13'($urandom));
        chk("trfc_early_err1", 32'(err[1]), 1);

        // Refresh-interval overrun
        repeat (T_REFI_MAX + 20) nop();
        chk("refi_err5", 32'(err[5]), 32'(REFI_EN));

        // Async reset at AREF1 then a clean restart
        do_reset();
        power_up();
        init_from(1, 6);
        do_reset();
        power_up();
        init_from(1, 9);
        chk("restart_init_done", 32'(init_done), 1);
        chk("restart_err",       32'(err),       0);
        chk("restart_aref_cnt",  32'(aref_cnt),  2);

        // EMR3 before EMR2: flagged, FSM holds and then accepts EMR2
        do_reset();
        power_up();
        issue_legal(K_PREA, 0, 2);
        issue_legal(K_LMR, 3, 2);
        chk("emr_order_err3",  32'(err[3]),    1);
        chk("emr_order_nodone", 32'(init_done), 0);
        init_from(2, 9);
        chk("emr_order_done",  32'(init_done), 1);

        // Randomized traffic from reset
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int r, c, b;
            logic [12:0] a;
            r = $urandom_range(0, 15);
            b = $urandom_range(0, 7);
            a = 13'($urandom);
            if (r <= 5) begin
                c = K_NOP;
            end else if (r <= 8 && m_step >= 1 && m_step <= 9) begin
                c = seq_code[m_step];
                if (c == K_LMR) begin
                    b = seq_ba[m_step];
                    if (seq_a8[m_step] != 2) a[8] = seq_a8[m_step][0];
                end
            end else begin
                case (r)
                    9:       c = K_PRE;
                    10:      c = K_PREA;
                    11:      c = K_AREF;
                    12:      c = K_LMR;
                    13:      c = K_ACT;
                    14:      c = ($urandom_range(0, 1) == 1) ? K_RD : K_WR;
                    default: c = ($urandom_range(0, 3) == 0) ? K_ILL : K_ACT;
                endcase
            end
            step(($urandom_range(0, 9) != 0), c, b, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ddr2_cmd_monitor
`default_nettype wire
